c3lib_cfgcsr_fast_pulse_spacer: RTL

Fast-domain stage that sits directly upstream of the fast-to-slow pulse crosser. It accepts request strobes that may arrive back to back, counts them as pending, and re-issues them one at a time. Each re-issued pulse is isolated, with a fixed width and a guaranteed low gap, so every request survives the fast-to-slow crossing as exactly one slow-domain pulse.

---
 rtl/c3lib_cfgcsr_fast_pulse_spacer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/c3lib_cfgcsr_fast_pulse_spacer.sv
// Fast-domain request spacer: queues request strobes and re-issues them
// as isolated fixed-width pulses with a guaranteed low gap between them.
module c3lib_cfgcsr_fast_pulse_spacer #(
    parameter int CNT_WIDTH   = 4,
    parameter int PULSE_WIDTH = 1,
    parameter int GAP_CYCLES  = 16
) (
    input  logic                 i_fastclk,
    input  logic                 i_fastrstn,
    input  logic                 i_req,
    input  logic                 i_flush,
    input  logic                 i_ovf_clr,
    output logic                 o_fastpulse,
    output logic [CNT_WIDTH-1:0] o_pending,
    output logic                 o_busy,
    output logic                 o_overflow
);

    localparam int MAXP = (PULSE_WIDTH > GAP_CYCLES) ? PULSE_WIDTH : GAP_CYCLES;
    localparam int PH_W = $clog2(MAXP + 1);

    localparam logic [PH_W-1:0]      PH_PULSE = PH_W'(PULSE_WIDTH - 1);
    localparam logic [PH_W-1:0]      PH_GAP   = PH_W'(GAP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } state_t;

    state_t               state_q, state_d;
    logic [PH_W-1:0]      phase_q, phase_d;
    logic [CNT_WIDTH-1:0] pending_q, pending_d;
    logic                 pulse_q, pulse_d;
    logic                 ovf_q, ovf_d;
    logic                 launch;
    logic                 consume;
    logic                 drop;

    // Sequencer: launch a pulse, hold it, then enforce the low gap.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        consume = 1'b0;
        launch  = ((pending_q != '0) || i_req) && !i_flush;
        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = PULSE;
                    phase_d = PH_PULSE;
                    consume = 1'b1;
                end
            end
            PULSE: begin
                if (phase_q == '0) begin
                    state_d = GAP;
                    phase_d = PH_GAP;
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            GAP: begin
                if (phase_q == '0) begin
                    if (launch) begin
                        state_d = PULSE;
                        phase_d = PH_PULSE;
                        consume = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
        pulse_d = (state_d == PULSE);
    end

    // Pending count: saturating, a same-cycle arrival and consume cancel out.
    always_comb begin
        pending_d = pending_q;
        drop      = 1'b0;
        if (i_flush) begin
            pending_d = '0;
        end else if (i_req && !consume) begin
            if (pending_q == CNT_MAX) begin
                drop = 1'b1;
            end else begin
                pending_d = pending_q + CNT_WIDTH'(1);
            end
        end else if (!i_req && consume) begin
            pending_d = pending_q - CNT_WIDTH'(1);
        end
    end

    // Sticky overflow: a drop this cycle beats a clear request.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (i_ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_fastclk) begin
        if (!i_fastrstn) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            pending_q <= '0;
            pulse_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            pending_q <= pending_d;
            pulse_q   <= pulse_d;
            ovf_q     <= ovf_d;
        end
    end

    assign o_fastpulse = pulse_q;
    assign o_pending   = pending_q;
    assign o_overflow  = ovf_q;
    assign o_busy      = (state_q != IDLE) || (pending_q != '0);

endmodule
